// File: rtl/fp_align_add.sv
// fp_align_add
// Mantissa alignment and addition stage of a floating-point adder. One
// operation is started from IDLE. The smaller-exponent mantissa is shifted
// right one bit per cycle until it lines up with the larger one. The two
// mantissas are then added, and the result is normalised by one bit if the
// addition carried out.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   reset     - asynchronous, active-high reset
//   start     - begin one operation (sampled only in IDLE)
//   ma        - larger-exponent mantissa (N bits, unsigned)
//   me        - smaller-exponent mantissa to be aligned (N bits, unsigned)
//   diff_expo - exponent difference = right-shift amount for me (8 bits)
//   busy      - high whenever the FSM is not in IDLE
//   done      - one-cycle pulse qualifying sum / expo_inc / sticky
//   sum       - aligned, added and 1-bit-normalised mantissa
//   expo_inc  - addition carried out, sum was shifted right by one
//   sticky    - OR of every bit shifted out of me or out of the sum
module fp_align_add #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] ma,
   input  logic [N-1:0] me,
   input  logic [7:0]   diff_expo,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         expo_inc,
   output logic         sticky
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      ADD   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t       state;
   logic [N-1:0] maReg;
   logic [N-1:0] meReg;
   logic [7:0]   count;
   logic         stickyAcc;

   logic [N:0]   addResult;
   logic [31:0]  diffWide;
   logic         diffTooBig;

   // The exponent difference is compared at 32 bits so that any N, including
   // N above 255, gives a correct "shift removes everything" decision.
   always_comb begin
      diffWide   = {24'd0, diff_expo};
      diffTooBig = (diffWide >= 32'(N));
      addResult  = {1'b0, maReg} + {1'b0, meReg};
   end

   // Single FSM process. Results and the busy/done flags are registered so
   // they change only on clock edges. sum/expo_inc/sticky are written only
   // on the ADD->DONE edge, so an operation aborted by reset never
   // disturbs them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         maReg     <= '0;
         meReg     <= '0;
         count     <= '0;
         stickyAcc <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         expo_inc  <= 1'b0;
         sticky    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  maReg <= ma;
                  busy  <= 1'b1;
                  if (diff_expo == 8'd0) begin
                     meReg     <= me;
                     stickyAcc <= 1'b0;
                     state     <= ADD;
                  end else if (!diffTooBig) begin
                     meReg     <= me;
                     stickyAcc <= 1'b0;
                     count     <= diff_expo;
                     state     <= SHIFT;
                  end else begin
                     // Every bit of me would fall off the end, so skip the
                     // shifting and fold all of me into the sticky bit.
                     meReg     <= '0;
                     stickyAcc <= |me;
                     state     <= ADD;
                  end
               end
            end
            SHIFT: begin
               meReg     <= meReg >> 1;
               stickyAcc <= stickyAcc | meReg[0];
               count     <= count - 8'd1;
               if (count == 8'd1) begin
                  state <= ADD;
               end
            end
            ADD: begin
               if (addResult[N]) begin
                  sum      <= addResult[N:1];
                  expo_inc <= 1'b1;
                  sticky   <= stickyAcc | addResult[0];
               end else begin
                  sum      <= addResult[N-1:0];
                  expo_inc <= 1'b0;
                  sticky   <= stickyAcc;
               end
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_align_add.sv
// tb_fp_align_add
// Self-checking bench for fp_align_add (N = 32). Directed cases plus
// randomised operations are compared against an arithmetic reference model.
module tb_fp_align_add;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] ma;
   logic [31:0] me;
   logic [7:0]  diff_expo;
   logic        busy;
   logic        done;
   logic [31:0] sum;
   logic        expo_inc;
   logic        sticky;

   int nAsserts;
   int nFails;

   fp_align_add #(.N(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .ma        (ma),
      .me        (me),
      .diff_expo (diff_expo),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .expo_inc  (expo_inc),
      .sticky    (sticky)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and reports a failure with tag and values.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Reference model: the exact sum of ma and me scaled down by 2^d, kept in
   // 64 bits. The integer part is split from the discarded fraction bits,
   // and a carry out of 32 bits costs one more bit of precision.
   task automatic refModel(input logic [31:0] a, input logic [31:0] e, input int d,
                           output logic [31:0] expSum, output logic expInc,
                           output logic expSticky, output int expLat);
      logic [63:0] kept;
      logic [63:0] lost;
      logic [63:0] total;
      if (d >= 32) begin
         kept = 64'd0;
         lost = {32'd0, e};
      end else begin
         kept = {32'd0, e} / (64'd1 << d);
         lost = {32'd0, e} % (64'd1 << d);
      end
      total = {32'd0, a} + kept;
      if (total >= 64'h1_0000_0000) begin
         expSum    = 32'(total / 2);
         expInc    = 1'b1;
         expSticky = (lost != 64'd0) || (total % 2 == 64'd1);
      end else begin
         expSum    = total[31:0];
         expInc    = 1'b0;
         expSticky = (lost != 64'd0);
      end
      expLat = (d == 0 || d >= 32) ? 1 : d + 1;
   endtask

   // Run one operation from IDLE. The inputs are scrambled after the start
   // edge, then latency, busy length, the results, the single done pulse and
   // the holding of the results are all checked.
   task automatic applyStimulus(input string tag, input logic [31:0] a,
                                input logic [31:0] e, input logic [7:0] d);
      logic [31:0] expSum;
      logic        expInc;
      logic        expSticky;
      int          expLat;
      int          edges;
      int          busyCnt;
      refModel(a, e, int'(d), expSum, expInc, expSticky, expLat);
      @(negedge clk);
      ma = a; me = e; diff_expo = d; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ma = $urandom; me = $urandom; diff_expo = 8'($urandom);
      edges   = 0;
      busyCnt = 0;
      while (done !== 1'b1 && edges < 300) begin
         if (busy === 1'b1) busyCnt++;
         @(posedge clk); #1;
         edges++;
      end
      if (busy === 1'b1) busyCnt++;
      checkOutput({tag, "_latency"}, 64'(edges), 64'(expLat));
      checkOutput({tag, "_busy_cycles"}, 64'(busyCnt), 64'(expLat + 1));
      checkOutput({tag, "_sum"}, 64'(sum), 64'(expSum));
      checkOutput({tag, "_expo_inc"}, 64'(expo_inc), 64'(expInc));
      checkOutput({tag, "_sticky"}, 64'(sticky), 64'(expSticky));
      @(posedge clk); #1;
      checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
      checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
      checkOutput({tag, "_sum_held"}, 64'(sum), 64'(expSum));
   endtask

   initial begin
      logic [31:0] holdSum;
      logic        holdInc;
      logic        holdSticky;
      int          holdLat;
      int          doneSeen;
      nAsserts = 0;
      nFails   = 0;
      reset = 1'b1; start = 1'b0; ma = '0; me = '0; diff_expo = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_sum", 64'(sum), 64'd0);
      checkOutput("reset_expo_inc", 64'(expo_inc), 64'd0);
      checkOutput("reset_sticky", 64'(sticky), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // directed cases
      applyStimulus("carry_d0", 32'h8000_0000, 32'h8000_0000, 8'd0);
      applyStimulus("shift1", 32'h4000_0000, 32'h8000_0001, 8'd1);
      applyStimulus("shift31", 32'h8000_0000, 32'hFFFF_FFFF, 8'd31);
      applyStimulus("big_d40", 32'h1234_5678, 32'h0000_0001, 8'd40);
      applyStimulus("exact_d32", 32'h0000_0001, 32'hFFFF_FFFF, 8'd32);
      applyStimulus("carry_shift", 32'hFFFF_FFFF, 32'h0000_0003, 8'd1);

      // reset in the middle of a shift: abort, no done, sum cleared
      @(negedge clk);
      ma = 32'hAAAA_AAAA; me = 32'h5555_5555; diff_expo = 8'd10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_sum", 64'(sum), 64'd0);
      checkOutput("abort_done", 64'(done), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) doneSeen++;
      end
      checkOutput("abort_no_done", 64'(doneSeen), 64'd0);
      applyStimulus("after_abort", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 8'd3);

      // start held high: one op per 8 cycles, nothing queued while busy
      refModel(32'h0123_4567, 32'h89AB_CDEF, 5, holdSum, holdInc, holdSticky, holdLat);
      @(negedge clk);
      ma = 32'h0123_4567; me = 32'h89AB_CDEF; diff_expo = 8'd5; start = 1'b1;
      doneSeen = 0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk); #1;
         if (i == 20) start = 1'b0;
         if (done === 1'b1) doneSeen++;
         checkOutput($sformatf("held_done_c%0d", i), 64'(done),
                     64'((i % 8 == 7) ? 1 : 0));
      end
      checkOutput("held_done_count", 64'(doneSeen), 64'd3);
      checkOutput("held_sum", 64'(sum), 64'(holdSum));
      checkOutput("held_sticky", 64'(sticky), 64'(holdSticky));

      // randomised operations, with a bias toward the interesting shift range
      for (int i = 0; i < 25; i++) begin
         applyStimulus($sformatf("rand%0d", i), $urandom, $urandom,
                       8'($urandom_range(0, 45)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
